// File: rtl/register_file.sv
// register_file: 128 x 128-bit SPU register file with six registered read
// ports (three per pipe), two writeback ports, stall hold and a sticky
// write-collision flag.
// Optional feature: RF_BYPASS_EN enables same-cycle write-to-read forwarding.
// Bit 0 is the MSB of every data and address bus.
module register_file #(
    parameter int unsigned ENTRIES = 128,
    parameter int unsigned WIDTH   = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [0:6]       ra_addr_even,
    input  logic [0:6]       rb_addr_even,
    input  logic [0:6]       rc_addr_even,
    input  logic [0:6]       ra_addr_odd,
    input  logic [0:6]       rb_addr_odd,
    input  logic [0:6]       rc_addr_odd,
    output logic [0:WIDTH-1] ra_even,
    output logic [0:WIDTH-1] rb_even,
    output logic [0:WIDTH-1] rc_even,
    output logic [0:WIDTH-1] ra_odd,
    output logic [0:WIDTH-1] rb_odd,
    output logic [0:WIDTH-1] rc_odd,
    input  logic [0:WIDTH-1] rt_even_wb,
    input  logic [0:6]       rt_addr_even_wb,
    input  logic             reg_write_even_wb,
    input  logic [0:WIDTH-1] rt_odd_wb,
    input  logic [0:6]       rt_addr_odd_wb,
    input  logic             reg_write_odd_wb,
    output logic             wr_conflict
);

    localparam int unsigned AW  = 7;
    localparam int unsigned NRD = 6;

    typedef logic [0:WIDTH-1] word_t;
    typedef logic [0:AW-1]    addr_t;

    word_t mem_q [ENTRIES];
    word_t mem_d [ENTRIES];
    word_t rd_q  [NRD];
    word_t rd_d  [NRD];
    addr_t rd_addr [NRD];
    logic  wr_conflict_q;
    logic  wr_conflict_d;

    // Read port address fan-in, even pipe first then odd.
    assign rd_addr[0] = ra_addr_even;
    assign rd_addr[1] = rb_addr_even;
    assign rd_addr[2] = rc_addr_even;
    assign rd_addr[3] = ra_addr_odd;
    assign rd_addr[4] = rb_addr_odd;
    assign rd_addr[5] = rc_addr_odd;

    // Writeback into storage; odd is applied last so it wins a collision.
    always_comb begin
        mem_d = mem_q;
        if (reg_write_even_wb) mem_d[rt_addr_even_wb] = rt_even_wb;
        if (reg_write_odd_wb)  mem_d[rt_addr_odd_wb]  = rt_odd_wb;
    end

    // Sticky collision flag: both pipes writing the same register.
    always_comb begin
        wr_conflict_d = wr_conflict_q;
        if (reg_write_even_wb && reg_write_odd_wb &&
            (rt_addr_even_wb == rt_addr_odd_wb)) begin
            wr_conflict_d = 1'b1;
        end
    end

    // Read operand selection: hold on stall, else storage with optional bypass.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_d[i] = rd_q[i];
            if (!stall) begin
                rd_d[i] = mem_q[rd_addr[i]];
`ifdef RF_BYPASS_EN
                if (reg_write_even_wb && (rt_addr_even_wb == rd_addr[i])) begin
                    rd_d[i] = rt_even_wb;
                end
                if (reg_write_odd_wb && (rt_addr_odd_wb == rd_addr[i])) begin
                    rd_d[i] = rt_odd_wb;
                end
`endif
            end
        end
    end

    // State registers with synchronous clear of storage, operands and flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q         <= '{default: '0};
            rd_q          <= '{default: '0};
            wr_conflict_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            rd_q          <= rd_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign ra_even     = rd_q[0];
    assign rb_even     = rd_q[1];
    assign rc_even     = rd_q[2];
    assign ra_odd      = rd_q[3];
    assign rb_odd      = rd_q[4];
    assign rc_odd      = rd_q[5];
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: vector table plus hand sequences for register_file.
// Expected operands follow the RF_BYPASS_EN setting of the build.
module tb_register_file;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [127:0] Z    = 128'h0;
    localparam logic [127:0] V1   = {8{16'h1111}};
    localparam logic [127:0] VA   = {8{16'hAAAA}};
    localparam logic [127:0] VD   = {64'hDEADDEADDEADDEAD, 64'hBEEFBEEFBEEFBEEF};
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] W1   = 128'h1;
    localparam logic [127:0] W2   = 128'h2;
    localparam logic [127:0] W5   = 128'h5;
    localparam logic [127:0] W9   = 128'h9;

    typedef struct {
        logic             rst;
        logic             stall;
        logic             we_e;
        logic [6:0]       ae;
        logic [127:0]     de;
        logic             we_o;
        logic [6:0]       ao;
        logic [127:0]     dout;
        logic [5:0][6:0]  ra;
        logic [5:0][127:0] exp;
        logic             conf;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset, stall;
    logic [0:6]   ra_addr_even, rb_addr_even, rc_addr_even;
    logic [0:6]   ra_addr_odd, rb_addr_odd, rc_addr_odd;
    logic [0:127] ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd;
    logic [0:127] rt_even_wb, rt_odd_wb;
    logic [0:6]   rt_addr_even_wb, rt_addr_odd_wb;
    logic         reg_write_even_wb, reg_write_odd_wb;
    logic         wr_conflict;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    vec_t sb[$];

    register_file dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .ra_addr_even     (ra_addr_even),
        .rb_addr_even     (rb_addr_even),
        .rc_addr_even     (rc_addr_even),
        .ra_addr_odd      (ra_addr_odd),
        .rb_addr_odd      (rb_addr_odd),
        .rc_addr_odd      (rc_addr_odd),
        .ra_even          (ra_even),
        .rb_even          (rb_even),
        .rc_even          (rc_even),
        .ra_odd           (ra_odd),
        .rb_odd           (rb_odd),
        .rc_odd           (rc_odd),
        .rt_even_wb       (rt_even_wb),
        .rt_addr_even_wb  (rt_addr_even_wb),
        .reg_write_even_wb(reg_write_even_wb),
        .rt_odd_wb        (rt_odd_wb),
        .rt_addr_odd_wb   (rt_addr_odd_wb),
        .reg_write_odd_wb (reg_write_odd_wb),
        .wr_conflict      (wr_conflict)
    );

    always #5 clk = ~clk;

    // Build one vector: same read address and expected value on all six ports.
    function automatic vec_t mk(input logic rst, input logic stl,
                                input logic we_e, input logic [6:0] ae, input logic [127:0] de,
                                input logic we_o, input logic [6:0] ao, input logic [127:0] dout,
                                input logic [6:0] a, input logic [127:0] e, input logic conf);
        vec_t v;
        v.rst = rst; v.stall = stl;
        v.we_e = we_e; v.ae = ae; v.de = de;
        v.we_o = we_o; v.ao = ao; v.dout = dout;
        for (int i = 0; i < 6; i++) begin
            v.ra[i]  = a;
            v.exp[i] = e;
        end
        v.conf = conf;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        logic [127:0] act [6];
        string pn [6];
        reset = v.rst; stall = v.stall;
        reg_write_even_wb = v.we_e; rt_addr_even_wb = v.ae; rt_even_wb = v.de;
        reg_write_odd_wb  = v.we_o; rt_addr_odd_wb  = v.ao; rt_odd_wb  = v.dout;
        ra_addr_even = v.ra[0]; rb_addr_even = v.ra[1]; rc_addr_even = v.ra[2];
        ra_addr_odd  = v.ra[3]; rb_addr_odd  = v.ra[4]; rc_addr_odd  = v.ra[5];
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        pn = '{"ra_even", "rb_even", "rc_even", "ra_odd", "rb_odd", "rc_odd"};
        act[0] = ra_even; act[1] = rb_even; act[2] = rc_even;
        act[3] = ra_odd;  act[4] = rb_odd;  act[5] = rc_odd;
        for (int i = 0; i < 6; i++) chk(pn[i], idx, act[i], e.exp[i]);
        chk("wr_conflict", idx, {127'b0, wr_conflict}, {127'b0, e.conf});
    endtask

    initial begin
        vec_t v;
        int n;

        // Reset, then reads of 0/5/127 return zero.
        tbl.push_back(mk(1, 0, 0, 0, Z, 0, 0, Z, 0, Z, 0));
        v = mk(0, 0, 0, 0, Z, 0, 0, Z, 0, Z, 0);
        v.ra[1] = 5; v.ra[2] = 127; v.ra[4] = 5; v.ra[5] = 127;
        tbl.push_back(v);
        // Basic writes, then read back one cycle later.
        v = mk(0, 0, 1, 3, V1, 1, 9, VA, 0, Z, 0);
        v.ra[1] = 5; v.ra[2] = 127; v.ra[4] = 5; v.ra[5] = 127;
        tbl.push_back(v);
        v = mk(0, 0, 0, 0, Z, 0, 0, Z, 3, V1, 0);
        v.ra[1] = 9; v.exp[1] = VA; v.ra[2] = 0; v.exp[2] = Z;
        v.ra[3] = 9; v.exp[3] = VA; v.ra[5] = 127; v.exp[5] = Z;
        tbl.push_back(v);
        // Odd same-cycle bypass to addr 12.
        v = mk(0, 0, 0, 0, Z, 1, 12, VD, 12, BYP ? VD : Z, 0);
        v.ra[1] = 3; v.exp[1] = V1; v.ra[2] = 9; v.exp[2] = VA;
        v.ra[4] = 0; v.exp[4] = Z;  v.ra[5] = 0; v.exp[5] = Z;
        tbl.push_back(v);
        tbl.push_back(mk(0, 0, 0, 0, Z, 0, 0, Z, 12, VD, 0));
        // Collision on addr 20: odd wins, flag sets.
        tbl.push_back(mk(0, 0, 1, 20, W1, 1, 20, W2, 20, BYP ? W2 : Z, 1));
        tbl.push_back(mk(0, 0, 0, 0, Z, 0, 0, Z, 20, W2, 1));
        // Even-only bypass.
        tbl.push_back(mk(0, 0, 1, 30, V1, 0, 0, Z, 30, BYP ? V1 : Z, 1));
        // Disabled writes to addr 4 have no effect, not even on bypass.
        tbl.push_back(mk(0, 0, 0, 4, ONES, 0, 4, ONES, 4, Z, 1));
        v = mk(0, 0, 0, 0, Z, 0, 0, Z, 4, Z, 1);
        v.ra[5] = 30; v.exp[5] = V1;
        tbl.push_back(v);
        // Sticky flag over 10 idle cycles.
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 0, 0, Z, 0, 0, Z, 20, W2, 1));
        // Reset ignores same-cycle writes and clears everything.
        tbl.push_back(mk(1, 0, 1, 5, V1, 1, 6, VA, 20, Z, 0));
        v = mk(0, 0, 0, 0, Z, 0, 0, Z, 5, Z, 0);
        v.ra[1] = 6; v.ra[2] = 20; v.ra[3] = 3;
        tbl.push_back(v);

        n = 0;
        foreach (tbl[i]) begin
            apply(tbl[i], n);
            n++;
        end

        // Stall: outputs freeze at 5 while addr 7 is rewritten to 9.
        apply(mk(0, 0, 1, 7, W5, 0, 0, Z, 0, Z, 0), n++);
        apply(mk(0, 0, 0, 0, Z, 0, 0, Z, 7, W5, 0), n++);
        apply(mk(0, 1, 0, 0, Z, 1, 7, W9, 1, W5, 0), n++);
        v = mk(0, 1, 0, 0, Z, 0, 0, Z, 2, W5, 0);
        v.ra[3] = 7;
        apply(v, n++);
        apply(mk(0, 1, 0, 0, Z, 0, 0, Z, 127, W5, 0), n++);
        v = mk(0, 0, 0, 0, Z, 0, 0, Z, 0, Z, 0);
        v.ra[4] = 7; v.exp[4] = W9;
        apply(v, n++);

        // Reset during stall clears outputs; stall then holds zeros.
        apply(mk(1, 1, 0, 0, Z, 0, 0, Z, 7, Z, 0), n++);
        apply(mk(0, 1, 1, 8, V1, 0, 0, Z, 7, Z, 0), n++);
        v = mk(0, 0, 0, 0, Z, 0, 0, Z, 8, V1, 0);
        v.ra[0] = 7; v.exp[0] = Z;
        apply(v, n++);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
